// File: rtl/parity_tx_sequencer_if.sv
// rtl/parity_tx_sequencer_if.sv - word handshake between producer and parity_tx_sequencer
// The inj_err signal exists only when PARITY_ERR_INJECT_EN is defined.
interface parity_tx_sequencer_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
`ifdef PARITY_ERR_INJECT_EN
  logic              inj_err;

  modport master (output in_data, output in_valid, output inj_err, input in_ready);
  modport slave  (input in_data, input in_valid, input inj_err, output in_ready);
`else
  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
`endif
endinterface

// File: rtl/parity_tx_sequencer.sv
// rtl/parity_tx_sequencer.sv - serial frame transmitter: start, data LSB first, parity, stop
// Optional feature macro: PARITY_ERR_INJECT_EN (per-frame parity inversion via inj_err).
module parity_tx_sequencer #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parity_tx_sequencer_if.slave in_if,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 frame_done_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [15:0] TICK_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  BIT_LAST  = 5'(DATA_W - 1);
  localparam logic        ODD_BIT   = (ODD_PARITY != 0);

  logic [2:0]        state_q, state_d;
  logic [15:0]       tick_q, tick_d;
  logic [4:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              accept;
  logic              tick_last;
  logic              inj;

  assign in_if.in_ready = (state_q == S_IDLE);
  assign accept         = in_if.in_valid && (state_q == S_IDLE);
  assign tick_last      = (tick_q == TICK_LAST);

`ifdef PARITY_ERR_INJECT_EN
  assign inj = in_if.inj_err;
`else
  assign inj = 1'b0;
`endif

  assign tx_o         = tx_q;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = (state_q == S_STOP) && tick_last;

  // Next-state: bit timing, frame sequencing, and the registered line value for the next state
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = 1'b1;

    if (state_q != S_IDLE) begin
      tick_d = tick_last ? 16'd0 : tick_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          shift_d = in_if.in_data;
          par_d   = (^in_if.in_data) ^ ODD_BIT ^ inj;
          bit_d   = 5'd0;
          tick_d  = 16'd0;
        end
      end
      S_START: begin
        if (tick_last) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = S_PARITY;
            bit_d   = 5'd0;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick_last) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered, so it is derived from where the FSM is going
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and forces the line idle-high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= 16'd0;
      bit_q   <= 5'd0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: doc/parity_tx_sequencer.md
Name: parity_tx_sequencer

Overview:
Serial frame transmitter that sequences the 4-bit parity datapath onto a single wire.
- Accepts a data word over a valid/ready handshake.
- Computes the parity bit internally as the XOR reduction of the word, inverted for odd parity.
- Shifts out a frame: start bit, data bits LSB first, parity bit, stop bit.
- Sits between a nibble producer and a serial link, or a bench-side receiver/checker.

Parameters:
DATA_W, 4, width of data word and number of data bits per frame (legal 1..16)
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx (legal 1..65535)
ODD_PARITY, 0, 0 = even parity bit (XOR of data), 1 = odd parity bit (XNOR of data)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  DATA_W  word to transmit, sampled on accept
in_valid  input  1  producer has a word
in_ready  output  1  block can accept; high only in IDLE
tx  output  1  serial line, idle high, registered
busy  output  1  high from the cycle after accept through the last STOP cycle
frame_done  output  1  one-cycle pulse in the final cycle of STOP

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE; tx=1, busy=0, frame_done=0, in_ready=1.
  - Bit counter, tick counter and shift register are cleared.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 asynchronously.
- Accept: in_valid && in_ready at a rising edge.
  - Latch in_data into the shift register.
  - Latch par = ^in_data ^ ODD_PARITY.
  - Move to START.
  - in_data changes after accept have no effect on the frame in flight.
- in_ready = (state == IDLE), combinational.
  - A producer holding in_valid high is accepted on the first IDLE cycle.
  - Back-to-back gap: exactly 1 IDLE cycle between frames.
- Per-bit timing: tick counter counts 0..CLKS_PER_BIT-1. The state/bit advances when tick == CLKS_PER_BIT-1.
- FSM (tx is registered and reflects the state it is in):
  - IDLE: tx=1, waits for accept.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = shift[0], shifted right after each bit; bit index 0..DATA_W-1; after index DATA_W-1, go to PARITY.
  - PARITY: tx = par for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 only in the final cycle, then IDLE.
- Latency:
  - tx falls on the clock edge that registers START, i.e. the cycle after accept.
  - Frame length is (DATA_W+3)*CLKS_PER_BIT cycles; defaults give 28.
- in_valid during busy is ignored (no accept), and the producer must hold it.
- Counters wrap only through state transitions; tick never exceeds CLKS_PER_BIT-1.
- CLKS_PER_BIT=1: one cycle per bit, and frame_done coincides with the single STOP cycle.

Optional Feature:
Macro PARITY_ERR_INJECT_EN.
- Defined:
  - Adds input port inj_err (1 bit), sampled on accept together with in_data.
  - If it is sampled 1, the transmitted parity bit is inverted (par ^ 1) for that frame only.
  - All other frame fields are unchanged.
- Undefined:
  - The port is absent.
  - Parity is always correct per ODD_PARITY.

Test Plan:
- Reset: rst_n=0 for 3 cycles then 1 -> tx=1, busy=0, in_ready=1, frame_done=0 throughout, and for 10 idle cycles after.
- ODD_PARITY=0, in_data=4'b1011 accepted -> tx bits (each 4 cycles) 0,1,1,0,1,1(par),1(stop); frame_done at cycle 28 after accept; busy high for 28 cycles.
- ODD_PARITY=1, in_data=4'b0000 then 4'b1111 with in_valid held -> parity bit 1 for both frames; second accept one cycle after the first frame_done; in_ready low throughout each frame.
- Full sweep, in_data 0..15 in sequence -> bench receiver reconstructs each word, and its parity bit equals the XOR of its bits (even mode) for all 16.
- Reset mid-frame: assert rst_n=0 during the DATA bit 2 period of 4'b0110 -> tx=1 immediately, IDLE; the next word 4'b0001 transmits a correct full frame.
- PARITY_ERR_INJECT_EN defined: in_data=4'b0011, inj_err=1, even mode -> parity bit 1 (correct is 0); the following frame with inj_err=0 carries parity 0.
